// File: rtl/yarvi_fetch.sv
// YARVI instruction fetch stage: sequential word fetch with credit-limited
// in-flight requests, an in-order {pc, insn} buffer and restart/kill handling.

`ifndef INIT_PC
`define INIT_PC 'h200
`endif

module yarvi_fetch #(
    parameter int unsigned   VMSB    = 63,
    parameter logic [VMSB:0] INIT_PC = `INIT_PC,
    parameter int unsigned   DEPTH   = 4
) (
    input  logic            clock,
    input  logic            reset_n,

    input  logic            restart,
    input  logic [VMSB:0]   restart_pc,

    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [VMSB:0]   imem_req_addr,

    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,

    output logic            fe_valid,
    output logic [VMSB:0]   fe_pc,
    output logic [31:0]     fe_insn,
    input  logic            fe_ready
);

    localparam int unsigned   AW      = $clog2(DEPTH);
    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam logic [VMSB:0] PC_STEP = (VMSB + 1)'(4);

    logic                started;
    logic [VMSB:0]       fetch_pc;
    logic [VMSB:0]       resp_pc;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       kill;
    logic [CW-1:0]       count;
    logic [AW-1:0]       head;
    logic [AW-1:0]       tail;
    logic [VMSB:0]       pc_buf   [DEPTH];
    logic [31:0]         insn_buf [DEPTH];

    logic                req_fire;
    logic                resp_keep;
    logic                consume;
    logic [CW:0]         credit_used;
    logic [CW-1:0]       outstanding_nxt;
    logic [VMSB:0]       restart_base;
    logic                unused_bits;

    // Credit counts buffered entries too, so every response has a free slot.
    assign credit_used    = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = started && (credit_used < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign fe_valid = (count != '0);
    assign fe_pc    = pc_buf[head];
    assign fe_insn  = insn_buf[head];

    assign req_fire     = imem_req_valid && imem_req_ready;
    assign resp_keep    = imem_resp_valid && (kill == '0) && !restart;
    assign consume      = fe_valid && fe_ready && !restart;
    assign restart_base = {restart_pc[VMSB:2], 2'b00};
    assign unused_bits  = ^restart_pc[1:0];

    always_comb begin
        outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_resp_valid);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            started     <= 1'b0;
            fetch_pc    <= INIT_PC;
            resp_pc     <= INIT_PC;
            outstanding <= '0;
            kill        <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            pc_buf      <= '{default: INIT_PC};
            insn_buf    <= '{default: '0};
        end else begin
            started     <= 1'b1;
            outstanding <= outstanding_nxt;
            if (restart) begin
                // Kill everything still in flight after this edge, old kills included.
                kill     <= outstanding_nxt;
                count    <= '0;
                head     <= '0;
                tail     <= '0;
                fetch_pc <= restart_base;
                resp_pc  <= restart_base;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + PC_STEP;
                if (imem_resp_valid && (kill != '0))
                    kill <= kill - 1'b1;
                if (resp_keep) begin
                    pc_buf[tail]   <= resp_pc;
                    insn_buf[tail] <= imem_resp_data;
                    tail           <= tail + 1'b1;
                    resp_pc        <= resp_pc + PC_STEP;
                end
                if (consume)
                    head <= head + 1'b1;
                count <= count + CW'(resp_keep) - CW'(consume);
            end
        end
    end

endmodule

// File: tb/tb_yarvi_fetch.sv
// Directed bench for yarvi_fetch: in-order memory model with per-request latency
// and a scoreboard of expected {pc, insn} keyed by accepted request addresses.

module tb_yarvi_fetch;

    localparam int unsigned VMSB    = 63;
    localparam logic [63:0] INIT_PC = 64'h0000_0000_0000_0200;
    localparam int unsigned DEPTH   = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        restart = 1'b0;
    logic [63:0] restart_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        fe_valid;
    logic [63:0] fe_pc;
    logic [31:0] fe_insn;
    logic        fe_ready = 1'b0;

    always #5 clock = ~clock;

    yarvi_fetch #(
        .VMSB    (VMSB),
        .INIT_PC (INIT_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .restart         (restart),
        .restart_pc      (restart_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .fe_valid        (fe_valid),
        .fe_pc           (fe_pc),
        .fe_insn         (fe_insn),
        .fe_ready        (fe_ready)
    );

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    bit          rdy = 1'b1;
    bit          mrdy = 1'b1;
    int          n_cons = 0;
    int          base;
    int          n;
    logic [63:0] pend_addr [$];
    int unsigned pend_due  [$];
    logic [63:0] exp_q     [$];
    logic [63:0] exp_fetch = INIT_PC;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, account handshakes, then sample #1 after the edge.
    task automatic step(input bit rs, input logic [63:0] tgt);
        logic [63:0] e;
        bit fire;
        bit cons;
        if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = word_at(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        restart        = rs;
        restart_pc     = tgt;
        fe_ready       = rdy;
        imem_req_ready = mrdy;
        fire = imem_req_valid && imem_req_ready;
        cons = fe_valid && fe_ready && !rs;
        if (fire) begin
            chk("req_addr", imem_req_addr, exp_fetch);
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + lat);
            exp_q.push_back(imem_req_addr);
            exp_fetch = exp_fetch + 64'd4;
        end
        if (cons) begin
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("fe_pc", fe_pc, e);
                chk("fe_insn", 64'(fe_insn), 64'(word_at(e)));
            end
            n_cons++;
        end
        if (rs) begin
            exp_q.delete();
            exp_fetch = {tgt[63:2], 2'b00};
        end
        @(posedge clock);
        #1;
        cyc++;
        chk("inv_credit", 64'((int'(dut.outstanding) + int'(dut.count)) <= int'(DEPTH)), 64'd1);
        chk("inv_kill", 64'(int'(dut.kill) <= int'(dut.outstanding)), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset_n = 1'b0;
        #2;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_req_addr", imem_req_addr, INIT_PC);
        chk("rst_fe_valid", 64'(fe_valid), 64'd0);
        chk("rst_fe_pc", fe_pc, INIT_PC);
        chk("rst_fe_insn", 64'(fe_insn), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Startup and sustained throughput at latency 1.
        rdy = 1'b1; mrdy = 1'b1; lat = 1;
        step(1'b0, '0);
        chk("first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("first_req_addr", imem_req_addr, INIT_PC);
        repeat (4) step(1'b0, '0);
        base = n_cons;
        repeat (10) step(1'b0, '0);
        chk("throughput", 64'(n_cons - base), 64'd10);

        // Downstream stall fills the buffer and stops requests.
        rdy = 1'b0;
        repeat (10) step(1'b0, '0);
        chk("stall_count", 64'(dut.count), 64'd4);
        chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
        rdy = 1'b1;
        base = n_cons;
        repeat (6) step(1'b0, '0);
        chk("stall_drain", 64'(n_cons - base), 64'd6);

        // Restart to unaligned 0x1002 with two requests in flight at latency 3.
        mrdy = 1'b0; lat = 3;
        repeat (8) step(1'b0, '0);
        mrdy = 1'b1;
        step(1'b0, '0);
        step(1'b0, '0);
        mrdy = 1'b0;
        chk("two_outstanding", 64'(dut.outstanding), 64'd2);
        step(1'b1, 64'h1002);
        mrdy = 1'b1;
        chk("restart_fe_valid_low", 64'(fe_valid), 64'd0);
        chk("restart_req_valid", 64'(imem_req_valid), 64'd1);
        chk("restart_req_addr", imem_req_addr, 64'h1000);
        chk("restart_kill", 64'(dut.kill), 64'd2);
        n = 0;
        while (!fe_valid && n < 20) begin step(1'b0, '0); n++; end
        chk("wait_fe_1000", 64'(n < 20), 64'd1);
        chk("first_pc_1000", fe_pc, 64'h1000);
        chk("first_insn_1000", 64'(fe_insn), 64'(word_at(64'h1000)));

        // Restart coinciding with a request handshake and a response, latency 2.
        mrdy = 1'b0; lat = 2;
        repeat (8) step(1'b0, '0);
        mrdy = 1'b1;
        step(1'b0, '0);
        step(1'b0, '0);
        chk("coinc_outstanding", 64'(dut.outstanding), 64'd2);
        chk("coinc_req_valid", 64'(imem_req_valid), 64'd1);
        step(1'b1, 64'h3000);
        chk("coinc_kill_2", 64'(dut.kill), 64'd2);
        chk("coinc_fe_valid_low", 64'(fe_valid), 64'd0);
        step(1'b0, '0);
        chk("coinc_kill_1", 64'(dut.kill), 64'd1);
        step(1'b0, '0);
        chk("coinc_kill_0", 64'(dut.kill), 64'd0);
        repeat (6) step(1'b0, '0);

        // Second restart while the first one's kill is still pending.
        mrdy = 1'b0; lat = 3;
        repeat (8) step(1'b0, '0);
        mrdy = 1'b1;
        step(1'b0, '0);
        mrdy = 1'b0;
        step(1'b1, 64'h1000);
        chk("dbl_kill_1", 64'(dut.kill), 64'd1);
        mrdy = 1'b1;
        step(1'b1, 64'h2000);
        chk("dbl_kill_2", 64'(dut.kill), 64'd2);
        n = 0;
        while (!fe_valid && n < 30) begin step(1'b0, '0); n++; end
        chk("wait_fe_2000", 64'(n < 30), 64'd1);
        chk("first_pc_2000", fe_pc, 64'h2000);
        chk("first_insn_2000", 64'(fe_insn), 64'(word_at(64'h2000)));
        repeat (6) step(1'b0, '0);

        // Asynchronous reset in the middle of a cycle with the buffer occupied.
        lat = 1;
        n = 0;
        while (!fe_valid && n < 20) begin step(1'b0, '0); n++; end
        chk("pre_reset_fe_valid", 64'(fe_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_fe_valid", 64'(fe_valid), 64'd0);
        chk("async_req_valid", 64'(imem_req_valid), 64'd0);
        chk("async_fe_pc", fe_pc, INIT_PC);
        chk("async_req_addr", imem_req_addr, INIT_PC);
        pend_addr.delete();
        pend_due.delete();
        exp_q.delete();
        exp_fetch = INIT_PC;
        imem_resp_valid = 1'b0;
        @(posedge clock);
        #1;
        cyc++;
        reset_n = 1'b1;
        step(1'b0, '0);
        chk("resume_req_valid", 64'(imem_req_valid), 64'd1);
        chk("resume_req_addr", imem_req_addr, INIT_PC);
        base = n_cons;
        repeat (12) step(1'b0, '0);
        chk("resume_progress", 64'(n_cons - base), 64'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
